// File: rtl/ram_dp_sync_be.sv
// ram_dp_sync_be
//   Synchronous true dual-port RAM with per-byte write enables, selectable
//   cross-port read-during-write behaviour, optional output register stage,
//   a post-reset clear sequencer and same-address collision flag.
//
//   Ports
//     clk, rst          clock and asynchronous active-high reset
//     init_busy         high while the clear sequencer owns the array
//     cs_x, we_x        port x select and write enable (x = 0, 1)
//     be_x              port x byte enables, bit i covers data[8i+7:8i]
//     address_x         port x word address
//     wdata_x, rdata_x  port x write / read data
//     rvalid_x          port x one-cycle read-data-valid pulse
//     collision         one-cycle pulse: same-address access with a write
//
//   Clear FSM
//     state    | meaning
//     ---------+-----------------------------------------------------------
//     ST_CLEAR | zeroing mem[clr_cnt_q] each cycle, both ports ignored
//     ST_RUN   | normal dual-port operation
module ram_dp_sync_be #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int RD_MODE    = 0,
  parameter int OUT_REG    = 0,
  parameter int INIT_CLEAR = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_busy,
  input  logic                  cs_0,
  input  logic                  we_0,
  input  logic [BE_WIDTH-1:0]   be_0,
  input  logic [ADDR_WIDTH-1:0] address_0,
  input  logic [DATA_WIDTH-1:0] wdata_0,
  output logic [DATA_WIDTH-1:0] rdata_0,
  output logic                  rvalid_0,
  input  logic                  cs_1,
  input  logic                  we_1,
  input  logic [BE_WIDTH-1:0]   be_1,
  input  logic [ADDR_WIDTH-1:0] address_1,
  input  logic [DATA_WIDTH-1:0] wdata_1,
  output logic [DATA_WIDTH-1:0] rdata_1,
  output logic                  rvalid_1,
  output logic                  collision
);

  localparam int               IDX_W     = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [32:0]      DEPTH_EXT = 33'(RAM_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(RAM_DEPTH - 1);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
  localparam logic [0:0] ST_RESET = (INIT_CLEAR != 0) ? ST_CLEAR : ST_RUN;

  logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

  logic [0:0]            state_q, state_d;
  logic [IDX_W-1:0]      clr_cnt_q, clr_cnt_d;

  logic                  run;
  logic                  in_rng_0, in_rng_1;
  logic                  same_addr;
  logic                  rd_0, rd_1, wr_0, wr_1;
  logic [IDX_W-1:0]      idx_0, idx_1;
  logic [DATA_WIDTH-1:0] rd_word_0, rd_word_1;

  logic [DATA_WIDTH-1:0] s1_data_0_q, s1_data_1_q;
  logic                  s1_valid_0_q, s1_valid_1_q;
  logic                  collision_q, collision_d;

  // Overlay the enabled bytes of new_w onto old_w.
  function automatic logic [DATA_WIDTH-1:0] merge(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [BE_WIDTH-1:0]   be
  );
    merge = old_w;
    for (int b = 0; b < BE_WIDTH; b++) begin
      if (be[b]) merge[8*b +: 8] = new_w[8*b +: 8];
    end
  endfunction

  assign run       = (state_q == ST_RUN);
  assign init_busy = (state_q == ST_CLEAR);

  // Widen before comparing so RAM_DEPTH == 2**ADDR_WIDTH needs no special case.
  assign in_rng_0  = (33'(address_0) < DEPTH_EXT);
  assign in_rng_1  = (33'(address_1) < DEPTH_EXT);
  assign idx_0     = address_0[IDX_W-1:0];
  assign idx_1     = address_1[IDX_W-1:0];
  assign same_addr = (address_0 == address_1);

  // Out-of-range reads are still accepted (they return zero); writes are not.
  assign rd_0 = run & cs_0 & ~we_0;
  assign rd_1 = run & cs_1 & ~we_1;
  assign wr_0 = run & cs_0 & we_0 & in_rng_0;
  assign wr_1 = run & cs_1 & we_1 & in_rng_1;

  assign collision_d = run & cs_0 & cs_1 & in_rng_0 & same_addr & (we_0 | we_1);

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == LAST_IDX) begin
        state_d   = ST_RUN;
        clr_cnt_d = '0;
      end
    end
  end

  // A reading port sees the other port's same-cycle write only in write-first mode.
  always_comb begin
    rd_word_0 = '0;
    if (in_rng_0) begin
      rd_word_0 = mem_q[idx_0];
      if ((RD_MODE != 0) && wr_1 && same_addr) rd_word_0 = merge(mem_q[idx_0], wdata_1, be_1);
    end
  end

  always_comb begin
    rd_word_1 = '0;
    if (in_rng_1) begin
      rd_word_1 = mem_q[idx_1];
      if ((RD_MODE != 0) && wr_0 && same_addr) rd_word_1 = merge(mem_q[idx_1], wdata_0, be_0);
    end
  end

  // Array has no reset; the clear sequencer is its only initialiser.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (wr_0 && wr_1 && same_addr) begin
      // Port 1 merged first so port 0 overrides bytes enabled on both.
      mem_q[idx_0] <= merge(merge(mem_q[idx_0], wdata_1, be_1), wdata_0, be_0);
    end else begin
      if (wr_0) mem_q[idx_0] <= merge(mem_q[idx_0], wdata_0, be_0);
      if (wr_1) mem_q[idx_1] <= merge(mem_q[idx_1], wdata_1, be_1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RESET;
      clr_cnt_q    <= '0;
      s1_data_0_q  <= '0;
      s1_data_1_q  <= '0;
      s1_valid_0_q <= 1'b0;
      s1_valid_1_q <= 1'b0;
      collision_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      s1_valid_0_q <= rd_0;
      s1_valid_1_q <= rd_1;
      collision_q  <= collision_d;
      if (rd_0) s1_data_0_q <= rd_word_0;
      if (rd_1) s1_data_1_q <= rd_word_1;
    end
  end

  // Collision always leaves at latency 1; only read data goes through the extra stage.
  assign collision = collision_q;

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] s2_data_0_q, s2_data_1_q;
      logic                  s2_valid_0_q, s2_valid_1_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s2_data_0_q  <= '0;
          s2_data_1_q  <= '0;
          s2_valid_0_q <= 1'b0;
          s2_valid_1_q <= 1'b0;
        end else begin
          s2_valid_0_q <= s1_valid_0_q;
          s2_valid_1_q <= s1_valid_1_q;
          if (s1_valid_0_q) s2_data_0_q <= s1_data_0_q;
          if (s1_valid_1_q) s2_data_1_q <= s1_data_1_q;
        end
      end

      assign rdata_0  = s2_data_0_q;
      assign rdata_1  = s2_data_1_q;
      assign rvalid_0 = s2_valid_0_q;
      assign rvalid_1 = s2_valid_1_q;
    end else begin : g_no_out_reg
      assign rdata_0  = s1_data_0_q;
      assign rdata_1  = s1_data_1_q;
      assign rvalid_0 = s1_valid_0_q;
      assign rvalid_1 = s1_valid_1_q;
    end
  endgenerate

endmodule

// File: doc/ram_dp_sync_be.md
Name: ram_dp_sync_be

Overview:
- Parametrised synchronous true dual-port RAM; next generation of the team's asynchronous dual-port RAM.
- Adds byte-write enables, two fully read/write ports, selectable read-during-write mode and optional output pipeline register.
- Adds a post-reset clear sequencer and same-address collision detection.
- Used for register files, TLB/cache tag arrays and per-thread context storage in the multithreaded CPU pipeline.

Parameters:
- DATA_WIDTH, 32, data word width; must be a multiple of 8.
- ADDR_WIDTH, 8, address width.
- RAM_DEPTH, 1<<ADDR_WIDTH, number of words; may be less than 2^ADDR_WIDTH.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width (derived; do not override).
- RD_MODE, 0, cross-port read-during-write: 0 = read-first (old data), 1 = write-first (new merged data).
- OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2.
- INIT_CLEAR, 1, 1 = zero all words after reset; 0 = no clear, contents undefined.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- init_busy  output  1  high while the clear sequence runs; ports ignored while high.
- cs_0  input  1  port 0 chip select.
- we_0  input  1  port 0 write enable (1 = write, 0 = read).
- be_0  input  BE_WIDTH  port 0 byte enables; bit i covers data bits [8i+7:8i].
- address_0  input  ADDR_WIDTH  port 0 address.
- wdata_0  input  DATA_WIDTH  port 0 write data.
- rdata_0  output  DATA_WIDTH  port 0 read data.
- rvalid_0  output  1  port 0 read data valid, one-cycle pulse.
- cs_1, we_1, be_1, address_1, wdata_1, rdata_1, rvalid_1: port 1, identical to port 0.
- collision  output  1  one-cycle pulse flagging a same-address conflict.

Behaviour:
- Reset (asynchronous assert, released synchronously by the user):
  - rdata_x = 0, rvalid_x = 0, collision = 0, any OUT_REG stage = 0.
  - init_busy = INIT_CLEAR; clear counter = 0.
- Clear FSM, states CLEAR and RUN; reset enters CLEAR if INIT_CLEAR = 1, else RUN.
  - CLEAR: each cycle write 0 to mem[counter], then increment counter.
  - After counter = RAM_DEPTH-1 is written, go to RUN; init_busy falls on that same edge.
  - The clear therefore takes exactly RAM_DEPTH cycles.
  - Reset asserted mid-clear restarts at counter 0.
  - In CLEAR, cs_x is ignored: no writes, rvalid_x stays 0, collision stays 0.
- Read (RUN, cs_x = 1, we_x = 0):
  - OUT_REG = 0: rdata_x and rvalid_x update on the next edge.
  - OUT_REG = 1: one edge later.
  - rvalid_x is high for exactly one cycle per accepted read.
  - rdata_x holds its last value when there is no read; back-to-back reads give one result per cycle.
- Write (RUN, cs_x = 1, we_x = 1):
  - On the edge, each byte i with be_x[i] = 1 is updated; other bytes are unchanged. be_x = 0 is a no-op.
  - A write never asserts rvalid_x.
- Out-of-range address (address_x >= RAM_DEPTH):
  - Writes are dropped.
  - Reads return 0 with rvalid_x = 1.
- Cross-port, same cycle, same in-range address:
  - One port reads, the other writes: RD_MODE = 0 returns pre-write data; RD_MODE = 1 returns the post-write merged word.
  - Both write: for bytes enabled on both ports, port 0 wins; bytes enabled on one port take that port's data.
  - Both read: normal, no collision.
- collision:
  - Asserted for one cycle, aligned with read-latency-1 timing regardless of OUT_REG, for any same-address same-cycle access where at least one port writes.
  - Never asserted in CLEAR or for out-of-range addresses.
- The memory array has no reset; only the clear FSM initialises it.

Test Plan:
- Clear: RAM_DEPTH = 16, INIT_CLEAR = 1, pulse rst while memory holds 0xA5A5A5A5 -> init_busy high exactly 16 cycles; then reading all 16 addresses returns 0, each with rvalid_0 one cycle after cs_0.
- Reset mid-clear: assert rst at clear cycle 7 -> init_busy stays high 16 further cycles after release; a port 1 write issued during busy to address 3 is lost, and address 3 reads 0.
- Byte enables: write 0x11223344 to address 5 with be_0 = 1111, then write 0xAABBCCDD with be_0 = 0101 -> port 1 read of address 5 returns 0x11BB33DD; with OUT_REG = 1 the result arrives 2 cycles after the read.
- Read-during-write: address 9 holds 0x0; same cycle, port 0 writes 0xDEADBEEF (be = 1111) and port 1 reads address 9 -> RD_MODE = 0 returns 0x00000000, RD_MODE = 1 returns 0xDEADBEEF; collision pulses once in both modes.
- Write-write collision: port 0 writes 0x000000FF (be = 0001) and port 1 writes 0x0000FF00 (be = 0011) to address 2 in the same cycle -> stored value 0x0000FFFF (byte 0 from port 0, byte 1 from port 1); collision = 1 for one cycle.
- Out of range: RAM_DEPTH = 12, ADDR_WIDTH = 4; write 0x5 to address 13, then read address 13 -> rdata = 0, rvalid = 1, no collision; addresses 0 to 11 are unchanged.
